// File: rtl/ps2_kbd_decoder.sv
// PS/2 Set-2 scancode to ASCII decoder with make/break/extended tracking,
// shift/caps modifiers and a first-word-fall-through output FIFO.
module ps2_kbd_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sc_valid,
    input  logic [7:0]       sc_data,
    input  logic             rd_en,
    input  logic             ovf_clr,
    output logic [7:0]       kbd_data,
    output logic             kbd_valid,
    output logic             fifo_full,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_make;
    logic             w_brk;
    logic             r_shift_l;
    logic             r_shift_r;
    logic             r_caps_held;
    logic             r_caps_on;
    logic [7:0]       w_base;
    logic             w_hit;
    logic             w_letter;
    logic [7:0]       w_char;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (sc_valid) begin
            unique case (r_state)
                IDLE:    w_next = (sc_data == 8'hF0) ? BRK :
                                  (sc_data == 8'hE0) ? EXT : IDLE;
                BRK:     w_next = IDLE;
                EXT:     w_next = (sc_data == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_make = 1'b0;
        w_brk  = 1'b0;
        if (sc_valid) begin
            w_make = (r_state == IDLE) && (sc_data != 8'hF0) && (sc_data != 8'hE0);
            w_brk  = (r_state == BRK);
        end
    end

    // caps_on only toggles on the first make so typematic repeat is harmless
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift_l   <= 1'b0;
            r_shift_r   <= 1'b0;
            r_caps_held <= 1'b0;
            r_caps_on   <= 1'b0;
        end else if (w_make || w_brk) begin
            if (sc_data == 8'h12) r_shift_l <= w_make;
            if (sc_data == 8'h59) r_shift_r <= w_make;
            if (sc_data == 8'h58) begin
                r_caps_held <= w_make;
                if (w_make && !r_caps_held) r_caps_on <= ~r_caps_on;
            end
        end
    end

    always_comb begin
        w_base   = 8'h00;
        w_hit    = 1'b1;
        w_letter = 1'b1;
        case (sc_data)
            8'h1C: w_base = 8'h61;
            8'h32: w_base = 8'h62;
            8'h21: w_base = 8'h63;
            8'h23: w_base = 8'h64;
            8'h24: w_base = 8'h65;
            8'h2B: w_base = 8'h66;
            8'h34: w_base = 8'h67;
            8'h33: w_base = 8'h68;
            8'h43: w_base = 8'h69;
            8'h3B: w_base = 8'h6A;
            8'h42: w_base = 8'h6B;
            8'h4B: w_base = 8'h6C;
            8'h3A: w_base = 8'h6D;
            8'h31: w_base = 8'h6E;
            8'h44: w_base = 8'h6F;
            8'h4D: w_base = 8'h70;
            8'h15: w_base = 8'h71;
            8'h2D: w_base = 8'h72;
            8'h1B: w_base = 8'h73;
            8'h2C: w_base = 8'h74;
            8'h3C: w_base = 8'h75;
            8'h2A: w_base = 8'h76;
            8'h1D: w_base = 8'h77;
            8'h22: w_base = 8'h78;
            8'h35: w_base = 8'h79;
            8'h1A: w_base = 8'h7A;
            default: begin
                w_letter = 1'b0;
                case (sc_data)
                    8'h45:   w_base = 8'h30;
                    8'h16:   w_base = 8'h31;
                    8'h1E:   w_base = 8'h32;
                    8'h26:   w_base = 8'h33;
                    8'h25:   w_base = 8'h34;
                    8'h2E:   w_base = 8'h35;
                    8'h36:   w_base = 8'h36;
                    8'h3D:   w_base = 8'h37;
                    8'h3E:   w_base = 8'h38;
                    8'h46:   w_base = 8'h39;
                    8'h29:   w_base = 8'h20;
                    8'h5A:   w_base = 8'h0D;
                    8'h66:   w_base = 8'h08;
                    default: w_hit  = 1'b0;
                endcase
            end
        endcase
    end

    assign w_char = (w_letter && ((r_shift_l | r_shift_r) ^ r_caps_on))
                    ? w_base - 8'h20 : w_base;

    assign fifo_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = rd_en && (r_count != '0);
    assign w_push    = w_make && w_hit && (!fifo_full || w_pop);
    assign w_drop    = w_make && w_hit && fifo_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_char;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign kbd_valid = (r_count != '0);
    assign kbd_data  = kbd_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign overflow  = r_ovf;
    assign count     = r_count;
endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed table-driven bench for ps2_kbd_decoder plus hand-written
// reset and overflow corner sequences.
module tb_ps2_kbd_decoder;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sc_valid = 1'b0;
    logic [7:0]    sc_data = 8'h00;
    logic          rd_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [7:0]    kbd_data;
    logic          kbd_valid;
    logic          fifo_full;
    logic          overflow;
    logic [CW-1:0] count;

    ps2_kbd_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sc_valid(sc_valid), .sc_data(sc_data),
        .rd_en(rd_en), .ovf_clr(ovf_clr), .kbd_data(kbd_data),
        .kbd_valid(kbd_valid), .fifo_full(fifo_full),
        .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [7:0]    d;
        logic          rd;
        logic          clr;
        logic [7:0]    ed;
        logic [CW-1:0] ec;
        logic          eo;
    } vec_t;

    vec_t tbl[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic add(input logic v, input logic [7:0] d, input logic rd,
                       input logic clr, input logic [7:0] ed,
                       input int ec, input logic eo);
        vec_t t;
        t.v = v; t.d = d; t.rd = rd; t.clr = clr;
        t.ed = ed; t.ec = CW'(ec); t.eo = eo;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [7:0] d,
                         input logic rd, input logic clr);
        @(negedge clk);
        sc_valid = v; sc_data = d; rd_en = rd; ovf_clr = clr;
        @(posedge clk);
        #1;
        sc_valid = 1'b0; sc_data = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic check(input string name, input logic [7:0] ed,
                         input logic [CW-1:0] ec, input logic eo);
        logic ev, ef;
        ev = (ec != '0);
        ef = (ec == CW'(DEPTH));
        n_run++;
        if (kbd_valid !== ev || kbd_data !== ed || count !== ec ||
            fifo_full !== ef || overflow !== eo) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b data=%02h count=%0d full=%0b ovf=%0b, want valid=%0b data=%02h count=%0d full=%0b ovf=%0b",
                     name, kbd_valid, kbd_data, count, fifo_full, overflow,
                     ev, ed, ec, ef, eo);
        end
    endtask

    initial begin
        // single press, pop
        add(1, 8'h1C, 0, 0, 8'h61, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        // shift + a, release shift, a
        add(1, 8'h12, 0, 0, 8'h00, 0, 0);
        add(1, 8'h1C, 0, 0, 8'h41, 1, 0);
        add(1, 8'hF0, 0, 0, 8'h41, 1, 0);
        add(1, 8'h12, 0, 0, 8'h41, 1, 0);
        add(1, 8'h1C, 0, 0, 8'h41, 2, 0);
        add(0, 8'h00, 1, 0, 8'h61, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        // caps with typematic repeat, then shift XOR caps
        add(1, 8'h58, 0, 0, 8'h00, 0, 0);
        add(1, 8'h58, 0, 0, 8'h00, 0, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0);
        add(1, 8'h58, 0, 0, 8'h00, 0, 0);
        add(1, 8'h32, 0, 0, 8'h42, 1, 0);
        add(1, 8'h12, 0, 0, 8'h42, 1, 0);
        add(1, 8'h32, 0, 0, 8'h42, 2, 0);
        add(1, 8'h16, 0, 0, 8'h42, 3, 0);
        add(0, 8'h00, 1, 0, 8'h62, 2, 0);
        add(0, 8'h00, 1, 0, 8'h31, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        // restore: caps off, shift released
        add(1, 8'h58, 0, 0, 8'h00, 0, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0);
        add(1, 8'h58, 0, 0, 8'h00, 0, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0);
        add(1, 8'h12, 0, 0, 8'h00, 0, 0);
        // extended sequences are discarded
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0);
        add(1, 8'h75, 0, 0, 8'h00, 0, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0);
        add(1, 8'h75, 0, 0, 8'h00, 0, 0);
        add(1, 8'h45, 0, 0, 8'h30, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        // specials and unmapped codes
        add(1, 8'h29, 0, 0, 8'h20, 1, 0);
        add(1, 8'h5A, 0, 0, 8'h20, 2, 0);
        add(1, 8'h66, 0, 0, 8'h20, 3, 0);
        add(1, 8'hE1, 0, 0, 8'h20, 3, 0);
        add(1, 8'hAA, 0, 0, 8'h20, 3, 0);
        add(1, 8'h1C, 0, 0, 8'h20, 4, 0);
        add(0, 8'h00, 1, 0, 8'h0D, 3, 0);
        add(0, 8'h00, 1, 0, 8'h08, 2, 0);
        add(0, 8'h00, 1, 0, 8'h61, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        // pop at empty ignored; push+pop at empty pushes
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        add(1, 8'h1C, 1, 0, 8'h61, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 8'h00, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].clr);
            check($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ec, tbl[i].eo);
        end

        // overflow: depth+1 presses of '1'
        for (int k = 1; k <= DEPTH + 1; k++) begin
            drive(1'b1, 8'h16, 1'b0, 1'b0);
            check($sformatf("fill%0d", k), 8'h31,
                  CW'((k > DEPTH) ? DEPTH : k), k > DEPTH);
        end
        drive(1'b1, 8'h16, 1'b0, 1'b1);
        check("ovf_set_wins", 8'h31, CW'(DEPTH), 1'b1);
        drive(1'b1, 8'h1E, 1'b1, 1'b0);
        check("full_push_pop", 8'h31, CW'(DEPTH), 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 8'h31, CW'(DEPTH), 1'b0);
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("drain%0d", k),
                  (k == DEPTH) ? 8'h00 : (k == DEPTH - 1) ? 8'h32 : 8'h31,
                  CW'(DEPTH - k), 1'b0);
        end

        // reset mid-sequence discards prefix and modifiers
        drive(1'b1, 8'h1C, 1'b0, 1'b0);
        check("pre_rst_push", 8'h61, CW'(1), 1'b0);
        drive(1'b1, 8'h58, 1'b0, 1'b0);
        drive(1'b1, 8'hF0, 1'b0, 1'b0);
        check("pre_rst_brk", 8'h61, CW'(1), 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", 8'h00, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 8'h1C, 1'b0, 1'b0);
        check("post_rst_make", 8'h61, CW'(1), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
